// File: rtl/brush_stamp_ctrl_pkg.sv
// brush_stamp_ctrl_pkg
//   Shared types and constants for the brush stamp controller slice.
//   state_t     : controller FSM states
//   RGB_WIDTH   : framebuffer pixel width
//   FB_DEPTH    : framebuffer size at the default 640x480 resolution
package brush_stamp_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SWEEP,
        CLEAR,
        DONE
    } state_t;

    localparam int unsigned RGB_WIDTH     = 3;
    localparam int unsigned RES_H_DEFAULT = 640;
    localparam int unsigned RES_V_DEFAULT = 480;
    localparam int unsigned FB_DEPTH      = RES_H_DEFAULT * RES_V_DEFAULT;

endpackage

// File: rtl/brush_stamp_ctrl_if.sv
// brush_stamp_ctrl_if
//   Bundles the brush-side request inputs, the framebuffer write port and
//   the status outputs of brush_stamp_ctrl.
//   master : controller view (requests/cursor/display_on in; fb_*/busy/done out)
//   slave  : surrounding system view (opposite directions)
interface brush_stamp_ctrl_if
    import brush_stamp_ctrl_pkg::*;
#(
    parameter int unsigned HPOS_WIDTH = 10,
    parameter int unsigned VPOS_WIDTH = 10,
    parameter int unsigned SIZE_WIDTH = 5,
    parameter int unsigned ADDR_WIDTH = $clog2(FB_DEPTH)
);

    logic                  paint_req;
    logic                  clear_req;
    logic [RGB_WIDTH-1:0]  color;
    logic [HPOS_WIDTH-1:0] cursor_xpos;
    logic [VPOS_WIDTH-1:0] cursor_ypos;
    logic [SIZE_WIDTH-1:0] brush_size;
    logic                  display_on;
    logic                  fb_we;
    logic [ADDR_WIDTH-1:0] fb_waddr;
    logic [RGB_WIDTH-1:0]  fb_wdata;
    logic                  busy;
    logic                  done;

    modport master (
        input  paint_req, clear_req, color, cursor_xpos, cursor_ypos,
               brush_size, display_on,
        output fb_we, fb_waddr, fb_wdata, busy, done
    );

    modport slave (
        output paint_req, clear_req, color, cursor_xpos, cursor_ypos,
               brush_size, display_on,
        input  fb_we, fb_waddr, fb_wdata, busy, done
    );

endinterface

// File: rtl/brush_stamp_ctrl_rect_clip.sv
// stamp_rect_clip
//   Combinational clip of a square of half-side size centred on (cx, cy)
//   against the screen. Inputs: cx, cy, size. Outputs: x0/x1, y0/y1
//   (inclusive bounds) and empty, set when the square lies fully off-screen.
module stamp_rect_clip #(
    parameter int unsigned RES_H      = 640,
    parameter int unsigned RES_V      = 480,
    parameter int unsigned HPOS_WIDTH = 10,
    parameter int unsigned VPOS_WIDTH = 10,
    parameter int unsigned SIZE_WIDTH = 5
) (
    input  logic [HPOS_WIDTH-1:0] cx,
    input  logic [VPOS_WIDTH-1:0] cy,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic [HPOS_WIDTH-1:0] x0,
    output logic [HPOS_WIDTH-1:0] x1,
    output logic [VPOS_WIDTH-1:0] y0,
    output logic [VPOS_WIDTH-1:0] y1,
    output logic                  empty
);

    localparam int unsigned XW = HPOS_WIDTH + 1;
    localparam int unsigned YW = VPOS_WIDTH + 1;

    // One extra bit: the MSB of *_lo flags underflow below 0.
    logic [XW-1:0] x_lo, x_hi;
    logic [YW-1:0] y_lo, y_hi;

    always_comb begin
        x_lo = {1'b0, cx} - XW'(size);
        x_hi = {1'b0, cx} + XW'(size) - XW'(1);
        y_lo = {1'b0, cy} - YW'(size);
        y_hi = {1'b0, cy} + YW'(size) - YW'(1);

        x0 = x_lo[XW-1] ? '0 : x_lo[HPOS_WIDTH-1:0];
        y0 = y_lo[YW-1] ? '0 : y_lo[VPOS_WIDTH-1:0];
        x1 = (x_hi > XW'(RES_H - 1)) ? HPOS_WIDTH'(RES_H - 1) : x_hi[HPOS_WIDTH-1:0];
        y1 = (y_hi > YW'(RES_V - 1)) ? VPOS_WIDTH'(RES_V - 1) : y_hi[VPOS_WIDTH-1:0];

        empty = (!x_lo[XW-1] && (x_lo > XW'(RES_H - 1))) ||
                (!y_lo[YW-1] && (y_lo > YW'(RES_V - 1)));
    end

endmodule

// File: rtl/brush_stamp_ctrl.sv
// brush_stamp_ctrl
//   Stamps the brush square at the cursor into the framebuffer, writing only
//   while display readout does not own the framebuffer (display_on low).
//   Optional full-screen clear sweep enabled by macro STAMP_CLEAR_EN.
//   Ports: clk, reset (sync, active-low), bus (brush_stamp_ctrl_if.master:
//   paint_req, clear_req, color, cursor_xpos/ypos, brush_size, display_on in;
//   fb_we, fb_waddr, fb_wdata, busy, done out).
module brush_stamp_ctrl
    import brush_stamp_ctrl_pkg::*;
#(
    parameter int unsigned          RESOLUTION_H = 640,
    parameter int unsigned          RESOLUTION_V = 480,
    parameter int unsigned          HPOS_WIDTH   = 10,
    parameter int unsigned          VPOS_WIDTH   = 10,
    parameter int unsigned          SIZE_WIDTH   = 5,
    parameter int unsigned          ADDR_WIDTH   = $clog2(RESOLUTION_H * RESOLUTION_V),
    parameter logic [RGB_WIDTH-1:0] CLEAR_COLOR  = 3'b000
) (
    input logic              clk,
    input logic              reset,
    brush_stamp_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RESOLUTION_H);

    state_t                state;
    logic [HPOS_WIDTH-1:0] x, x0, x1;
    logic [VPOS_WIDTH-1:0] y, y1;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [RGB_WIDTH-1:0]  color_q;
    logic                  busy_q, done_q;

    logic [HPOS_WIDTH-1:0] clip_x0, clip_x1;
    logic [VPOS_WIDTH-1:0] clip_y0, clip_y1;
    logic                  clip_empty;

    stamp_rect_clip #(
        .RES_H      (RESOLUTION_H),
        .RES_V      (RESOLUTION_V),
        .HPOS_WIDTH (HPOS_WIDTH),
        .VPOS_WIDTH (VPOS_WIDTH),
        .SIZE_WIDTH (SIZE_WIDTH)
    ) u_clip (
        .cx    (bus.cursor_xpos),
        .cy    (bus.cursor_ypos),
        .size  (bus.brush_size),
        .x0    (clip_x0),
        .x1    (clip_x1),
        .y0    (clip_y0),
        .y1    (clip_y1),
        .empty (clip_empty)
    );

`ifdef STAMP_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RESOLUTION_H * RESOLUTION_V - 1);
    logic [ADDR_WIDTH-1:0] clr_addr;
`else
    logic [RGB_WIDTH-1:0] unused_clear;
    assign unused_clear = CLEAR_COLOR ^ {RGB_WIDTH{bus.clear_req}};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            x        <= '0;
            x0       <= '0;
            x1       <= '0;
            y        <= '0;
            y1       <= '0;
            row_base <= '0;
            color_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef STAMP_CLEAR_EN
            clr_addr <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
`ifdef STAMP_CLEAR_EN
                    if (bus.clear_req) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        busy_q   <= 1'b1;
                    end else
`endif
                    if (bus.paint_req) begin
                        state  <= SETUP;
                        busy_q <= 1'b1;
                    end
                end
                SETUP: begin
                    color_q  <= bus.color;
                    x        <= clip_x0;
                    x0       <= clip_x0;
                    x1       <= clip_x1;
                    y        <= clip_y0;
                    y1       <= clip_y1;
                    row_base <= ADDR_WIDTH'(clip_y0) * ROW_STEP;
                    if (bus.brush_size == '0 || clip_empty) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    // Counters only move on cycles that actually wrote.
                    if (!bus.display_on) begin
                        if (x == x1) begin
                            if (y == y1) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                x        <= x0;
                                y        <= y + VPOS_WIDTH'(1);
                                row_base <= row_base + ROW_STEP;
                            end
                        end else begin
                            x <= x + HPOS_WIDTH'(1);
                        end
                    end
                end
`ifdef STAMP_CLEAR_EN
                CLEAR: begin
                    if (!bus.display_on) begin
                        if (clr_addr == LAST_ADDR) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
`endif
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    logic                  we_c;
    logic [ADDR_WIDTH-1:0] waddr_c;
    logic [RGB_WIDTH-1:0]  wdata_c;

    always_comb begin
        we_c    = 1'b0;
        waddr_c = '0;
        wdata_c = '0;
        case (state)
            SWEEP: begin
                we_c    = !bus.display_on;
                waddr_c = row_base + ADDR_WIDTH'(x);
                wdata_c = color_q;
            end
`ifdef STAMP_CLEAR_EN
            CLEAR: begin
                we_c    = !bus.display_on;
                waddr_c = clr_addr;
                wdata_c = CLEAR_COLOR;
            end
`endif
            default: ;
        endcase
    end

    assign bus.fb_we    = we_c;
    assign bus.fb_waddr = waddr_c;
    assign bus.fb_wdata = wdata_c;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: doc/brush_stamp_ctrl.md
Name: brush_stamp_ctrl

Overview:
- Sequences framebuffer writes that "stamp" the brush square at the current cursor position.
- Sits between the brush block (cursor_xpos, cursor_ypos, brush_size) and the framebuffer write port.
- Schedules the shared framebuffer so writes happen only in cycles where display readout does not own it (display_on low).
- Also owns a full-screen clear sweep (optional feature).

Parameters:
- RESOLUTION_H, 640, horizontal pixels
- RESOLUTION_V, 480, vertical pixels
- HPOS_WIDTH, 10, x coordinate width
- VPOS_WIDTH, 10, y coordinate width
- SIZE_WIDTH, 5, brush_size width
- ADDR_WIDTH, $clog2(RESOLUTION_H*RESOLUTION_V), framebuffer address width
- CLEAR_COLOR, 3'b000, fill colour for clear

Ports:
- clk  in  1  system clock
- reset  in  1  reset; synchronous, active-low
- paint_req  in  1  level; stamp while high
- clear_req  in  1  level; clear screen (used only with macro)
- color  in  3  brush RGB
- cursor_xpos  in  HPOS_WIDTH  brush centre x
- cursor_ypos  in  VPOS_WIDTH  brush centre y
- brush_size  in  SIZE_WIDTH  half-side of the square
- display_on  in  1  high = framebuffer owned by readout, no write
- fb_we  out  1  framebuffer write strobe
- fb_waddr  out  ADDR_WIDTH  write address, y*RESOLUTION_H+x
- fb_wdata  out  3  write RGB
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of stamp or clear

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - All outputs 0.
  - Internal counters 0.
- FSM states: IDLE, SETUP, SWEEP, CLEAR, DONE.
- IDLE:
  - clear_req (macro on) has priority over paint_req: go to CLEAR.
  - Otherwise, if paint_req, go to SETUP.
  - Requests are sampled only in IDLE.
- SETUP (1 cycle):
  - Snapshot cursor, size and colour. Later input changes do not affect the stamp in progress.
  - x0=max(cx-size,0); x1=min(cx+size-1,RESOLUTION_H-1). Same for y against RESOLUTION_V.
  - Compute in width+1 bits to detect underflow and overflow.
  - row_base=y0*RESOLUTION_H, computed with one multiply in SETUP.
  - If size==0, go directly to DONE with no writes.
- SWEEP, raster order, x inner loop:
  - Each cycle with display_on==0: fb_we=1, fb_waddr=row_base+x, fb_wdata=snapshot colour. Then advance x.
  - At x==x1: x=x0, y++, row_base+=RESOLUTION_H (adder only, no multiply).
  - After the write of (x1,y1), go to DONE.
  - Cycles with display_on==1: fb_we=0 and counters hold. No write is dropped or duplicated.
- Output timing:
  - fb_we, fb_waddr and fb_wdata are combinational from state, counters and display_on.
  - First write is possible 2 cycles after paint_req is seen in IDLE.
- CLEAR:
  - addr runs 0 .. RESOLUTION_H*RESOLUTION_V-1, wdata=CLEAR_COLOR.
  - Same display_on gating as SWEEP.
  - After the last address, go to DONE.
- DONE (1 cycle): done=1, then IDLE.
  - If paint_req is still high, the next stamp starts on the following IDLE cycle (held button repaints).
- busy=1 in every state except IDLE.
- Reset mid-operation: the sweep is abandoned and fb_we drops at that edge. No done pulse is produced.

Optional Feature:
- Macro STAMP_CLEAR_EN.
- Defined: clear_req is honoured with the CLEAR state and priority described above.
- Undefined: the CLEAR state, its counter and the CLEAR_COLOR path are not compiled. clear_req is ignored. The port remains present for a stable interface.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SETUP, SWEEP, CLEAR, DONE);
  - localparam FB_DEPTH=RESOLUTION_H*RESOLUTION_V;
  - RGB width constant (3).
- One natural sub-module: stamp_rect_clip. It is combinational: it takes cursor, size and resolution and produces x0, x1, y0, y1, reused by any future shape stamp.

Test Plan:
- Cursor (320,240), size 10, display_on=0, paint_req pulsed → exactly 400 writes. First addr 147510, last 159689, wdata=color, one done pulse, busy drops.
- Same stamp with display_on toggling 50% → still 400 unique writes in raster order. fb_we never high while display_on=1; completion takes about 2x the cycles.
- Cursor (5,5), size 10 → clipped to x 0..14, y 0..14. 225 writes, first addr 0, last 14*640+14=8974.
- Cursor change and colour change during SWEEP → all writes use the snapshot values. paint_req held → a second stamp starts after done.
- STAMP_CLEAR_EN defined, clear_req and paint_req raised in the same cycle → 307200 writes of CLEAR_COLOR, addr 0..307199, done, then the stamp runs. Undefined → only the stamp runs.
- reset=0 mid-SWEEP → next cycle fb_we=0, busy=0, done=0. A new paint_req after release restarts from the first address.
